univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter: RESET_VAL, default {WIDTH{1'b0}}, value loaded into q on reset and on CLEAR.
REQ-003 Derived constant: CW = $clog2(WIDTH), width of the shift counter.
REQ-004 Port: clk  input  1  rising-edge clock; all state updates occur on this edge except reset.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: en  input  1  operation enable; when 0, all state holds regardless of mode.
REQ-007 Port: mode  input  3  operation select (encoding in REQ-012).
REQ-008 Port: d  input  WIDTH  parallel load data.
REQ-009 Port: sin  input  1  serial input bit for SHL (enters LSB) and SHR (enters MSB).
REQ-010 Port: q  output  WIDTH  register contents, driven directly from flops.
REQ-011 Ports:
- so  output  1  registered copy of the last bit shifted or rotated out.
- shift_cnt  output  CW  count of shift/rotate operations, modulo WIDTH.
- wrap  output  1  one-cycle registered pulse when shift_cnt wraps from WIDTH-1 to 0.

Function
REQ-012 mode encoding, applied on a rising clk edge with en=1:
- 000 HOLD: q unchanged.
- 001 SHL: q <= {q[W-2:0], sin}.
- 010 SHR: q <= {sin, q[W-1:1]}.
- 011 ROL: q <= {q[W-2:0], q[W-1]}.
- 100 ROR: q <= {q[0], q[W-1:1]}.
- 101 ASR: q <= {q[W-1], q[W-1:1]}.
- 110 LOAD: q <= d.
- 111 CLEAR: q <= RESET_VAL.
REQ-013 Single-cycle latency: q reflects the operation on the same edge that samples en/mode; there is no internal pipelining.
REQ-014 On SHL/ROL, so SHALL be loaded with the pre-edge q[WIDTH-1]; on SHR/ROR/ASR, with the pre-edge q[0]; on all other modes, or when en=0, so holds.
REQ-015 shift_cnt SHALL increment by 1 on every enabled SHL, SHR, ROL, ROR or ASR, wrapping WIDTH-1 -> 0.
REQ-016 wrap SHALL be 1 for exactly the cycle after the edge on which shift_cnt goes WIDTH-1 -> 0, and 0 otherwise.
REQ-017 On LOAD or CLEAR, shift_cnt SHALL be set to 0 and wrap SHALL be 0; so holds.
REQ-018 On HOLD, or whenever en=0, shift_cnt holds and wrap SHALL be 0.
REQ-019 Mixing shift directions is allowed; shift_cnt counts operations, not net displacement.
REQ-020 X or Z on mode while en=0 SHALL NOT alter state.

Reset
REQ-021 While rst_n=0, outputs SHALL be: q=RESET_VAL, so=0, shift_cnt=0, wrap=0.
REQ-022 Reset SHALL act immediately on the falling edge of rst_n, independent of clk, including mid-operation between clock edges.
REQ-023 The first clk edge at which rst_n is sampled 1 SHALL perform a normal operation; no extra recovery cycle is inserted.

Verification (WIDTH=8, RESET_VAL=0 unless noted)
REQ-024 Load then shift: LOAD d=0xA5, then SHL with sin=1 -> q=0x4B, so=1, shift_cnt=1.
REQ-025 Rotate wrap: LOAD 0x81, then 8x ROL -> q=0x81 after the 8th; shift_cnt=0; wrap=1 for exactly one cycle; so=1 after the 1st and 8th ROL.
REQ-026 Arithmetic shift: LOAD 0x80, then 3x ASR -> 0xC0, 0xE0, 0xF0; SHR with sin=0 on 0xF0 -> 0x78.
REQ-027 Enable gating: en=0 for 5 cycles while mode cycles through all 8 codes -> q, so, shift_cnt unchanged; wrap=0 throughout.
REQ-028 Async reset mid-operation, with RESET_VAL=0x3C: during a shift sequence with shift_cnt=5, drop rst_n between clk edges -> q=0x3C, shift_cnt=0, so=0 before the next edge; release -> next edge SHL sin=0 gives q=0x78.
REQ-029 CLEAR vs. counter: after 7 shifts, CLEAR -> q=RESET_VAL, shift_cnt=0, and no wrap pulse on the next shift.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/arith-shift/load/clear, single-cycle, gated by en.
// No backpressure; en=0 freezes all state, shift_cnt/wrap track shift-class operations.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic [CW-1:0]    shift_cnt,
  output logic             wrap
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'd0,
    M_SHL   = 3'd1,
    M_SHR   = 3'd2,
    M_ROL   = 3'd3,
    M_ROR   = 3'd4,
    M_ASR   = 3'd5,
    M_LOAD  = 3'd6,
    M_CLEAR = 3'd7
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  mode_e            op;
  logic [WIDTH-1:0] q_nxt;
  logic             so_nxt;
  logic             shifting;
  logic             restart;

  assign op = mode_e'(mode);

  // mode is only decoded under en, so an undriven mode while disabled cannot disturb state
  always_comb begin
    q_nxt    = q;
    so_nxt   = so;
    shifting = 1'b0;
    restart  = 1'b0;
    if (en) begin
      case (op)
        M_SHL: begin
          q_nxt    = {q[WIDTH-2:0], sin};
          so_nxt   = q[WIDTH-1];
          shifting = 1'b1;
        end
        M_SHR: begin
          q_nxt    = {sin, q[WIDTH-1:1]};
          so_nxt   = q[0];
          shifting = 1'b1;
        end
        M_ROL: begin
          q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
          so_nxt   = q[WIDTH-1];
          shifting = 1'b1;
        end
        M_ROR: begin
          q_nxt    = {q[0], q[WIDTH-1:1]};
          so_nxt   = q[0];
          shifting = 1'b1;
        end
        M_ASR: begin
          q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
          so_nxt   = q[0];
          shifting = 1'b1;
        end
        M_LOAD: begin
          q_nxt   = d;
          restart = 1'b1;
        end
        M_CLEAR: begin
          q_nxt   = RESET_VAL;
          restart = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= RESET_VAL;
      so        <= 1'b0;
      shift_cnt <= '0;
      wrap      <= 1'b0;
    end else begin
      q    <= q_nxt;
      so   <= so_nxt;
      wrap <= 1'b0;
      if (restart) begin
        shift_cnt <= '0;
      end else if (shifting) begin
        // explicit compare so non-power-of-two widths still wrap at WIDTH-1
        if (shift_cnt == CNT_MAX) begin
          shift_cnt <= '0;
          wrap      <= 1'b1;
        end else begin
          shift_cnt <= shift_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: default instance plus a RESET_VAL=0x3C instance on shared stimulus.
module tb_univ_shift_reg;

  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                         ROR  = 3'd4, ASR = 3'd5, LOAD = 3'd6, CLEAR = 3'd7;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;

  logic [7:0] q0, q1;
  logic       so0, so1;
  logic [2:0] cnt0, cnt1;
  logic       wrap0, wrap1;

  int checks   = 0;
  int failures = 0;

  univ_shift_reg #(.WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q0), .so(so0), .shift_cnt(cnt0), .wrap(wrap0)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q1), .so(so1), .shift_cnt(cnt1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive on the falling edge, return 1 time unit after the next rising edge
  task automatic do_op(input logic e, input logic [2:0] m, input logic [7:0] dv, input logic s);
    @(negedge clk);
    en   = e;
    mode = m;
    d    = dv;
    sin  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq, input logic eso,
                             input logic [2:0] ecnt, input logic ewrap);
    check({tag, ".q"},    {24'd0, q0},   {24'd0, eq});
    check({tag, ".so"},   {31'd0, so0},  {31'd0, eso});
    check({tag, ".cnt"},  {29'd0, cnt0}, {29'd0, ecnt});
    check({tag, ".wrap"}, {31'd0, wrap0}, {31'd0, ewrap});
  endtask

  logic [7:0] rol_q  [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
  logic       rol_so [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] shl_q  [7] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
  logic [7:0] ror_q  [5] = '{8'h8F, 8'hC7, 8'hE3, 8'hF1, 8'hF8};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = HOLD;
    d     = 8'h00;
    sin   = 1'b0;

    #12;
    check_state("reset0", 8'h00, 1'b0, 3'd0, 1'b0);
    check("reset1.q", {24'd0, q1}, 32'h3C);

    // release with an operation already presented: the very next edge must act
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = LOAD;
    d     = 8'hA5;
    @(posedge clk);
    #1;
    check_state("first_load", 8'hA5, 1'b0, 3'd0, 1'b0);

    do_op(1'b1, SHL, 8'h00, 1'b1);
    check_state("shl_a5", 8'h4B, 1'b1, 3'd1, 1'b0);

    do_op(1'b1, LOAD, 8'h81, 1'b0);
    check_state("load_81", 8'h81, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, ROL, 8'h00, 1'b0);
      check_state($sformatf("rol%0d", i + 1), rol_q[i], rol_so[i], 3'((i + 1) % 8), (i == 7));
    end
    do_op(1'b1, HOLD, 8'h00, 1'b0);
    check_state("after_wrap", 8'h81, 1'b1, 3'd0, 1'b0);

    do_op(1'b1, LOAD, 8'h80, 1'b0);
    do_op(1'b1, ASR, 8'h00, 1'b1);
    check_state("asr1", 8'hC0, 1'b0, 3'd1, 1'b0);
    do_op(1'b1, ASR, 8'h00, 1'b1);
    check_state("asr2", 8'hE0, 1'b0, 3'd2, 1'b0);
    do_op(1'b1, ASR, 8'h00, 1'b1);
    check_state("asr3", 8'hF0, 1'b0, 3'd3, 1'b0);
    do_op(1'b1, SHR, 8'h00, 1'b0);
    check_state("shr0", 8'h78, 1'b0, 3'd4, 1'b0);
    do_op(1'b1, SHR, 8'h00, 1'b1);
    check_state("shr1", 8'hBC, 1'b0, 3'd5, 1'b0);
    do_op(1'b1, ROR, 8'h00, 1'b0);
    check_state("ror_bc", 8'h5E, 1'b0, 3'd6, 1'b0);
    do_op(1'b1, ASR, 8'h00, 1'b0);
    check_state("asr_5e", 8'h2F, 1'b0, 3'd7, 1'b0);
    do_op(1'b1, ROR, 8'h00, 1'b0);
    check_state("ror_wrap", 8'h97, 1'b1, 3'd0, 1'b1);
    do_op(1'b1, SHL, 8'h00, 1'b1);
    check_state("shl_97", 8'h2F, 1'b1, 3'd1, 1'b0);

    // disabled: every mode code plus an unknown one must leave state alone
    for (int i = 0; i < 9; i++) begin
      do_op(1'b0, (i < 8) ? 3'(i) : 3'bxxx, 8'hFF, 1'b1);
      check_state($sformatf("gate%0d", i), 8'h2F, 1'b1, 3'd1, 1'b0);
    end

    do_op(1'b1, LOAD, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      do_op(1'b1, SHL, 8'h00, 1'b1);
      check("clr_seq.q", {24'd0, q0}, {24'd0, shl_q[i]});
    end
    check("clr_seq.cnt", {29'd0, cnt0}, 32'd7);
    do_op(1'b1, CLEAR, 8'h00, 1'b0);
    check_state("clear", 8'h00, 1'b0, 3'd0, 1'b0);
    check("clear1.q", {24'd0, q1}, 32'h3C);
    do_op(1'b1, SHL, 8'h00, 1'b0);
    check_state("post_clear", 8'h00, 1'b0, 3'd1, 1'b0);

    do_op(1'b1, LOAD, 8'h1F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, ROR, 8'h00, 1'b0);
      check("ror_seq1.q", {24'd0, q1}, {24'd0, ror_q[i]});
    end
    check("pre_rst1.cnt", {29'd0, cnt1}, 32'd5);
    check("pre_rst1.so", {31'd0, so1}, 32'd1);

    // drop reset between edges and observe it before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("arst1.q",    {24'd0, q1},    32'h3C);
    check("arst1.cnt",  {29'd0, cnt1},  32'd0);
    check("arst1.so",   {31'd0, so1},   32'd0);
    check("arst1.wrap", {31'd0, wrap1}, 32'd0);
    check("arst0.q",    {24'd0, q0},    32'h00);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = SHL;
    sin   = 1'b0;
    @(posedge clk);
    #1;
    check("rel1.q",   {24'd0, q1},   32'h78);
    check("rel1.cnt", {29'd0, cnt1}, 32'd1);
    check("rel1.so",  {31'd0, so1},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
